// File: rtl/conv_enc_frame_ctrl_if.sv
// Handshake and framed-output bundle for conv_enc_frame_ctrl.
// master drives frame requests and data; slave is the sequencer.
interface conv_enc_frame_ctrl_if;
  logic       start;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_parities;
  logic       out_first;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    output start, in_valid, in_bit,
    input  in_ready, out_valid, out_parities,
    input  out_first, out_last, busy, done
  );

  modport slave (
    input  start, in_valid, in_bit,
    output in_ready, out_valid, out_parities,
    output out_first, out_last, busy, done
  );
endinterface

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for the K=3 rate-1/2 (7,5) convolutional encoder.
// Optional shadow encoder checker: define CONV_CTRL_CHECK_EN.
module conv_enc_frame_ctrl #(
  parameter int FRAME_LEN = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  conv_enc_frame_ctrl_if.slave bus,
  output logic       enc_bit,
  input  logic [1:0] enc_parities
`ifdef CONV_CTRL_CHECK_EN
  ,
  output logic       chk_err
`endif
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LOAD,
    S_ENC,
    S_TAIL,
    S_DRAIN
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [FRAME_LEN-1:0]   frame_q;
  logic                   fed_q, first_q;
  logic                   accept, sel_bit, in_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_FLUSH;
      cnt     <= '0;
      frame_q <= '0;
      fed_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      for (int i = 0; i < FRAME_LEN; i++)
        if (accept && cnt == CW'(i))
          frame_q[i] <= bus.in_bit;
      fed_q   <= (state == S_ENC) || (state == S_TAIL);
      first_q <= (state == S_ENC) && (cnt == '0);
    end
  end

  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++)
      if (cnt == CW'(i))
        sel_bit = frame_q[i];
  end

  // enc_bit stays 0 outside ENC so the encoder drains to 00
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    enc_bit  = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    unique case (state)
      S_FLUSH: begin
        cnt_n = cnt + ONE;
        if (cnt == ONE) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_LOAD;
          cnt_n   = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        if (bus.in_valid) begin
          cnt_n = cnt + ONE;
          if (cnt == LAST) begin
            state_n = S_ENC;
            cnt_n   = '0;
          end
        end
      end
      S_ENC: begin
        enc_bit = sel_bit;
        cnt_n   = cnt + ONE;
        if (cnt == LAST) begin
          state_n = S_TAIL;
          cnt_n   = '0;
        end
      end
      S_TAIL: begin
        cnt_n = cnt + ONE;
        if (cnt == ONE) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end
      end
      S_DRAIN: state_n = S_IDLE;
      default: state_n = S_FLUSH;
    endcase
  end

  assign bus.in_ready     = in_ready;
  assign bus.busy         = (state != S_IDLE);
  assign bus.out_valid    = fed_q;
  assign bus.out_first    = first_q;
  assign bus.out_last     = fed_q && (state == S_DRAIN);
  assign bus.done         = fed_q && (state == S_DRAIN);
  assign bus.out_parities = fed_q ? enc_parities : 2'b00;

`ifdef CONV_CTRL_CHECK_EN
  logic [1:0] sh_s, exp_p;
  logic       err_q, mis;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_s  <= 2'b00;
      exp_p <= 2'b00;
      err_q <= 1'b0;
    end else begin
      if (state == S_FLUSH && cnt == ONE)
        sh_s <= 2'b00;
      else
        sh_s <= {sh_s[0], enc_bit};
      exp_p <= {enc_bit ^ sh_s[0] ^ sh_s[1],
                enc_bit ^ sh_s[1]};
      if (mis)
        err_q <= 1'b1;
    end
  end

  assign mis     = fed_q && (enc_parities != exp_p);
  assign chk_err = err_q | mis;
`endif

endmodule

// File: doc/conv_enc_frame_ctrl.md
Name: conv_enc_frame_ctrl

Overview:
- Frame sequencer for the K=3, rate-1/2 convolutional encoder (generators 7,5 octal; 2-bit state).
- Buffers one frame of FRAME_LEN data bits, then streams them into the encoder on consecutive cycles and appends two zero tail bits so the encoder ends in state 00.
- Qualifies the encoder's parity pairs with valid/first/last markers.
- The encoder has no enable or reset, so this block owns its input every cycle and drives 0 whenever it is not feeding frame bits.

Parameters:
- FRAME_LEN, 8, data bits per frame (>=2); the counter is $clog2(FRAME_LEN+1) bits wide.

Ports:
- CLK  in  1  clock; everything is sampled on posedge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request; honoured only in IDLE.
- in_valid  in  1  data bit valid (LOAD phase).
- in_bit  in  1  data bit.
- in_ready  out  1  high in LOAD only.
- enc_bit  out  1  bit to the encoder input (combinational from state, count and buffer).
- enc_parities  in  2  registered parity output of the encoder.
- out_valid  out  1  out_parities holds a frame pair.
- out_parities  out  2  equals enc_parities, forced to 00 when out_valid=0.
- out_first  out  1  first pair of the frame.
- out_last  out  1  last (second tail) pair of the frame.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, coincident with out_last.

Behaviour:
- Reset (RST_N=0, async):
  - state=FLUSH, cnt=0, buffer cleared.
  - out_valid, out_first, out_last and done are 0; in_ready=0, enc_bit=0, busy=1.
- States:
  - FLUSH: enc_bit=0 for 2 cycles after RST_N rises, which returns the encoder to 00 from any state. Then go to IDLE. start is ignored.
  - IDLE: enc_bit=0, in_ready=0. start=1 -> LOAD with cnt=0.
  - LOAD: in_ready=1. Each in_valid&in_ready stores in_bit into buf[cnt] and increments cnt. Gaps in in_valid are allowed.
    - The accept with cnt==FRAME_LEN-1 -> ENC with cnt=0; in_ready drops the next cycle.
    - enc_bit=0 throughout LOAD.
  - ENC: enc_bit=buf[cnt], where buf[0] is the first bit received. cnt increments every cycle.
    - No stall is possible.
    - After FRAME_LEN cycles -> TAIL with cnt=0.
  - TAIL: enc_bit=0 for 2 cycles -> DRAIN.
  - DRAIN: 1 cycle, then -> IDLE.
- Output timing:
  - The encoder registers its parities on the same edge that samples enc_bit.
  - The fed flag is registered, so out_valid is high from the cycle after the first ENC cycle through DRAIN: exactly FRAME_LEN+2 consecutive cycles.
  - out_first is on the first of these cycles; out_last and done are on the DRAIN cycle.
- Total latency:
  - from the last LOAD accept to the first out_valid: 2 cycles;
  - from the first out_valid to done: FRAME_LEN+1 cycles.
- Boundary conditions:
  - start outside IDLE (including the DRAIN cycle) is dropped, not queued.
  - in_valid outside LOAD is ignored.
  - Reset mid-frame aborts immediately. No out_last or done is issued, and the mandatory FLUSH runs before the next frame.
- Encoder model, used for checking and by CONV_CTRL_CHECK_EN:
  - s starts at 00.
  - p[1] = in^s[0]^s[1].
  - p[0] = in^s[1].
  - next s = {s[0], in}.

Optional Feature:
- Macro CONV_CTRL_CHECK_EN.
- Defined:
  - A shadow copy of the encoder model is tracked from enc_bit; it is reset to 00 by RST_N and by FLUSH completion.
  - Each out_valid cycle compares the expected pair against enc_parities.
  - On a mismatch, the extra output port chk_err (1 bit, sticky) is set. It is cleared only by reset.
- Undefined: the chk_err port and the shadow logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: RST_N low for 3 cycles, then high. enc_bit=0 and busy=1 for 2 cycles, then busy=0. A start during FLUSH is ignored (no in_ready).
- Basic frame (FRAME_LEN=4), bits 1,0,1,1 -> out_parities 11,10,00,01,01,11 on 6 consecutive out_valid cycles. out_first is on the first pair; out_last and done are on the sixth.
- LOAD gaps: in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 bits accepted. The ENC output is unchanged versus the gapless case.
- Back-to-back frames: start asserted on the DRAIN cycle is dropped; start asserted in the following IDLE is accepted. Frame 2 = 0,0,0,0 -> six 00 pairs, which proves the encoder was left in 00.
- Mid-frame reset: RST_N pulsed low during ENC -> no done pulse. The next frame 1,1,1,1 yields 11,01,10,10,01,11.
- Checker (CONV_CTRL_CHECK_EN): force enc_parities bit 0 inverted on the third pair -> chk_err rises the same cycle and stays high until reset.
